// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: default sizing and the per-stage control record for pipe_adder
package pipe_adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_t;
endpackage

// File: rtl/add_chunk.sv
// add_chunk: W-bit ripple adder exposing carry-out and the carry into its MSB
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign cmsb = a[W-1] ^ b[W-1] ^ sum[W-1];
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: skewed carry-pipelined adder, one CHUNK per stage, valid/ready handshake
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});
  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad
    $error("pipe_adder: illegal WIDTH/STAGES combination");
  end
  stage_t ctl_r [STAGES];
  stage_t ctl_n [STAGES];
  // acc holds finished sum chunks below the current stage and untouched a chunks above
  logic [WIDTH-1:0] acc_r [STAGES];
  logic [WIDTH-1:0] acc_n [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] b_n [STAGES];
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    logic [WIDTH-1:0] op_a, op_b;
    logic ci, vi, co, cm;
    logic [CHUNK-1:0] s;
    if (k == 0) begin : g_first
      assign {op_a, op_b, ci, vi} = {a, b, cin, in_valid};
    end else begin : g_next
      assign {op_a, op_b, ci, vi} = {acc_r[k-1], b_r[k-1], ctl_r[k-1].carry, ctl_r[k-1].valid};
    end
    add_chunk #(.W(CHUNK)) u_add (
      .a(op_a[LO +: CHUNK]),
      .b(op_b[LO +: CHUNK]),
      .cin(ci),
      .sum(s),
      .cout(co),
      .cmsb(cm)
    );
    assign acc_n[k] = (op_a & ~(MASK << LO)) | (WIDTH'(s) << LO);
    assign b_n[k] = op_b;
    assign ctl_n[k] = '{valid: vi, carry: co, ovf: cm ^ co};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_r <= '{default: '0};
      acc_r <= '{default: '0};
      b_r <= '{default: '0};
    end else if (adv) begin
      ctl_r <= ctl_n;
      acc_r <= acc_n;
      b_r <= b_n;
    end
  end
  assign out_valid = ctl_r[STAGES-1].valid;
  assign cout = ctl_r[STAGES-1].carry;
  assign ovf = ctl_r[STAGES-1].ovf;
  assign sum = acc_r[STAGES-1];
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder plus STAGES=1/16 latency builds
module tb_pipe_adder;
  localparam int W = 16;
  localparam int S = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  logic rdy1, v1, c1, o1, rdy16, v16, c16, o16;
  logic [W-1:0] sum1, sum16;
  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );
  pipe_adder #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .cin(cin), .out_valid(v1), .out_ready(1'b1),
    .sum(sum1), .cout(c1), .ovf(o1)
  );
  pipe_adder #(.WIDTH(W), .STAGES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .a(a), .b(b), .cin(cin), .out_valid(v16), .out_ready(1'b1),
    .sum(sum16), .cout(c16), .ovf(o16)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W+1:0] res;
    int cyc;
  } ent_t;
  ent_t q[$];
  int total = 0, bad = 0, cyc = 0;
  bit lat_chk = 0, stall_chk = 0, have_snap = 0, quiet_chk = 0, aux_on = 0, seen1 = 0, seen16 = 0;
  logic [W+2:0] snap;
  int aux_cyc = 0, lat1 = -1, lat16 = -1;
  logic [W+1:0] res1 = '0, res16 = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {(x[W-1] == y[W-1]) && (t[W-1] != x[W-1]), t};
  endfunction
  task automatic cycle(output bit acc);
    ent_t e;
    #1;
    acc = rst_n && in_valid && in_ready;
    if (acc) q.push_back('{model(a, b, cin), cyc});
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        e = q.pop_front();
        check("result", {ovf, cout, sum}, e.res);
        if (lat_chk) check("latency", cyc - e.cyc, S);
      end
    end
    if (stall_chk && !out_ready) begin
      check("stall_in_ready", in_ready, 0);
      if (have_snap) check("stall_frozen", {out_valid, ovf, cout, sum}, snap);
      else begin
        snap = {out_valid, ovf, cout, sum};
        have_snap = 1;
      end
    end
    if (quiet_chk) check("post_reset_quiet", out_valid, 0);
    if (aux_on && v1 && !seen1) begin
      seen1 = 1;
      lat1 = cyc - aux_cyc;
      res1 = {o1, c1, sum1};
    end
    if (aux_on && v16 && !seen16) begin
      seen16 = 1;
      lat16 = cyc - aux_cyc;
      res16 = {o16, c16, sum16};
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    bit acc = 0;
    a = x;
    b = y;
    cin = c;
    in_valid = 1;
    for (int i = 0; i < 10 && !acc; i++) cycle(acc);
    check("accepted", acc, 1);
  endtask
  task automatic drain();
    bit acc;
    in_valid = 0;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(acc);
    check("drain_empty", q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bit acc;
    logic [W-1:0] ra [10];
    logic [W-1:0] rb [10];
    logic rc [10];
    int idx;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    #1 check("release_in_ready", in_ready, 1);
    @(negedge clk);
    lat_chk = 1;
    send(16'h1234, 16'h0F0F, 0);
    send(16'hFFFF, 16'h0000, 1);
    send(16'h7FFF, 16'h0001, 0);
    send(16'h8000, 16'h8000, 0);
    drain();
    lat_chk = 0;
    for (int i = 0; i < 10; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      rc[i] = 1'($urandom_range(0, 1));
    end
    stall_chk = 1;
    idx = 0;
    for (int t = 0; t < 60 && idx < 10; t++) begin
      a = ra[idx];
      b = rb[idx];
      cin = rc[idx];
      in_valid = 1;
      out_ready = !(t >= 6 && t <= 9);
      cycle(acc);
      if (acc) idx++;
    end
    stall_chk = 0;
    out_ready = 1;
    check("stream_sent", idx, 10);
    drain();
    out_ready = 0;
    a = '0;
    for (int i = 0; i < 3; i++) begin
      a = a + 16'h1111;
      b = 16'h0101;
      cin = 1;
      in_valid = 1;
      cycle(acc);
    end
    in_valid = 0;
    cycle(acc);
    check("pre_reset_valid", out_valid, 1);
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    quiet_chk = 1;
    repeat (8) cycle(acc);
    quiet_chk = 0;
    repeat (20) cycle(acc);
    aux_on = 1;
    lat_chk = 1;
    a = 16'h1234;
    b = 16'h0F0F;
    cin = 0;
    in_valid = 1;
    aux_cyc = cyc;
    cycle(acc);
    in_valid = 0;
    repeat (20) cycle(acc);
    aux_on = 0;
    check("s1_latency", lat1, 1);
    check("s1_result", res1, 18'h02143);
    check("s16_latency", lat16, 16);
    check("s16_result", res16, 18'h02143);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
